// File: rtl/parity_frame_accum_pkg.sv
// Shared types, mode constants and counter helper for the frame parity accumulator.
package parity_frame_accum_pkg;

   // Two-state frame controller: accumulating beats, or holding a finished result.
   typedef enum logic [0:0] {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Frame polarity selection as sampled from odd_mode on the first beat.
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Saturating increment; callers widen their counter to 32 bits and pass its ceiling.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
      logic [31:0] res;
      if (cnt >= max_val) begin
         res = max_val;
      end else begin
         res = cnt + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one beat; usable as a stand-alone parity helper.
module parity_reduce #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] data,
   output logic             parity
);

   // Even parity of a vector, written out bit by bit.
   function automatic logic xor_reduce(input logic [WIDTH-1:0] v);
      logic p;
      p = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         p = p ^ v[i];
      end
      return p;
   endfunction

   // Pure combinational reduction, no state.
   always_comb begin
      parity = xor_reduce(data);
   end

endmodule

// File: rtl/parity_frame_accum.sv
// Frame parity accumulator: folds a valid/ready beat stream into one parity bit,
// a saturating beat count and an overflow flag per in_last-delimited frame.
// CNT_W is limited to 1..32 by the 32-bit counter helper.
module parity_frame_accum
   import parity_frame_accum_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             odd_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   state_t           state;
   logic             acc;
   logic             first;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             mode_q;

   logic             beat_par;
   logic             accept;
   logic             mode_eff;
   logic             acc_next;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;

   parity_reduce #(.WIDTH(WIDTH)) u_reduce (
      .data   (in_data),
      .parity (beat_par)
   );

   // Handshake flags come straight from the state register.
   assign in_ready  = (state == ACC);
   assign out_valid = (state == HOLD);

   // Next accumulator, polarity and counter values for a beat accepted this cycle.
   always_comb begin
      accept   = in_valid && (state == ACC);
      mode_eff = first ? odd_mode : mode_q;
      if (first) begin
         acc_next = beat_par;
         cnt_next = CNT_ONE;
         ovf_next = 1'b0;
      end else begin
         acc_next = acc ^ beat_par;
         cnt_next = CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
         ovf_next = ovf | (cnt == CNT_MAX);
      end
   end

   // Frame controller: accumulate beats in ACC, present and hold the result in HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ACC;
         acc        <= 1'b0;
         first      <= 1'b1;
         cnt        <= '0;
         ovf        <= 1'b0;
         mode_q     <= PAR_EVEN;
         out_parity <= 1'b0;
         out_beats  <= '0;
         out_ovf    <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (accept) begin
                  mode_q <= mode_eff;
                  cnt    <= cnt_next;
                  ovf    <= ovf_next;
                  if (in_last) begin
                     state      <= HOLD;
                     out_parity <= acc_next ^ mode_eff;
                     out_beats  <= cnt_next;
                     out_ovf    <= ovf_next;
                     acc        <= 1'b0;
                     first      <= 1'b1;
                  end else begin
                     acc   <= acc_next;
                     first <= 1'b0;
                  end
               end else begin
                  state <= ACC;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= ACC;
               end else begin
                  state <= HOLD;
               end
            end
            default: begin
               state <= ACC;
            end
         endcase
      end
   end

endmodule
